// File: rtl/turn_sequencer.sv
// Game-flow FSM: hands turns between players, strobes D on matched flips and latches the winner.
// Optional macro TURN_TIMEOUT_EN adds a WAIT_FLIP forfeit timer of TIMEOUT_CYCLES cycles.
module turn_sequencer #(
    parameter int NUM_PLAYERS_MAX = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] num_players,
    input  logic       flip_valid,
    input  logic       flip_match,
    input  logic       win_in,
    output logic [1:0] T,
    output logic       D,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [7:0] turn_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FLIP,
        ST_COMMIT,
        ST_CHECK,
        ST_PASS,
        ST_OVER
    } state_t;

    localparam logic [1:0] NP_LAST = 2'(NUM_PLAYERS_MAX - 1);

    state_t     state;
    state_t     next_state;
    logic [1:0] np_eff;
    logic [1:0] t_next_turn;

    // A single-player game is not meaningful, so zero behaves as two players.
    assign np_eff = (num_players == 2'd0) ? 2'd1 :
                    ((num_players > NP_LAST) ? NP_LAST : num_players);
    assign t_next_turn = (T >= np_eff) ? 2'd0 : T + 2'd1;

`ifdef TURN_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt;

    // Counts cycles spent in WAIT_FLIP; zero on every fresh entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT_FLIP && next_state == ST_WAIT_FLIP) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_WAIT_FLIP;
            end
            ST_WAIT_FLIP: begin
                if (flip_valid) begin
                    next_state = flip_match ? ST_COMMIT : ST_PASS;
                end
`ifdef TURN_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    next_state = ST_PASS;
                end
`endif
            end
            ST_COMMIT: next_state = ST_CHECK;
            ST_CHECK:  next_state = win_in ? ST_OVER : ST_WAIT_FLIP;
            ST_PASS:   next_state = ST_WAIT_FLIP;
            ST_OVER: begin
                if (start) next_state = ST_WAIT_FLIP;
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state into flops so nothing reaches a port combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            T         <= 2'd0;
            D         <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'd0;
            turn_cnt  <= 8'd0;
        end else begin
            D         <= (next_state == ST_COMMIT);
            busy      <= (next_state != ST_IDLE) && (next_state != ST_OVER);
            game_over <= (next_state == ST_OVER);

            if ((state == ST_IDLE || state == ST_OVER) && start) begin
                T        <= 2'd0;
                turn_cnt <= 8'd0;
                winner   <= 2'd0;
            end

            if (state == ST_PASS) begin
                T <= t_next_turn;
                if (turn_cnt != 8'hFF) turn_cnt <= turn_cnt + 8'd1;
            end

            if (state == ST_CHECK && win_in) begin
                winner <= T;
            end
        end
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-flow FSM directly upstream of the win-checking/position datapath.
- Accepts card-flip events from the input/card stage. Drives the current-player index `T` and the one-cycle commit strobe `D` consumed by the per-player position counters.
- Samples the win flag returned by that datapath and, on a win, latches the game-over condition and the winner.

Parameters:
- NUM_PLAYERS_MAX, 4, upper bound on players; `T` is 2 bits wide.
- TIMEOUT_CYCLES, 50_000_000, cycles allowed in WAIT_FLIP before the turn is forfeited (used only with TURN_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a game from IDLE.
- num_players  in  2  active players minus 1; legal values 1..3 (2..4 players). Value 0 is treated as 1.
- flip_valid  in  1  one-cycle pulse; a card has been flipped.
- flip_match  in  1  flipped card matches the target tile; valid only with flip_valid.
- win_in  in  1  win flag returned by the win-checking datapath.
- T  out  2  current player index, 0..num_players.
- D  out  1  commit strobe, high exactly one cycle per matched flip.
- busy  out  1  high in every state except IDLE and OVER.
- game_over  out  1  high while in OVER.
- winner  out  2  player index that won; valid while game_over is high.
- turn_cnt  out  8  completed turn hand-overs; saturates at 255.

Behaviour:
- Reset (async): state=IDLE, T=0, D=0, busy=0, game_over=0, winner=0, turn_cnt=0, timeout counter=0.
- States: IDLE, WAIT_FLIP, COMMIT, CHECK, PASS, OVER. Encoding is free.
- IDLE:
  - start=1 -> WAIT_FLIP; T=0, turn_cnt=0.
  - flip_valid is ignored.
- WAIT_FLIP:
  - flip_valid & flip_match -> COMMIT.
  - flip_valid & !flip_match -> PASS.
  - start is ignored.
- COMMIT: D=1 for this single cycle, then -> CHECK. Position counters update on this clock edge.
- CHECK:
  - win_in is sampled one cycle after D.
  - win_in=1 -> OVER; winner=T.
  - win_in=0 -> WAIT_FLIP with the same T (a correct flip keeps the turn).
- PASS:
  - T <= (T==num_players) ? 0 : T+1.
  - turn_cnt += 1, saturating at 255.
  - -> WAIT_FLIP.
- OVER:
  - game_over=1; T and winner are held.
  - start=1 -> WAIT_FLIP, clearing game_over, winner, turn_cnt and T.
- Flip handling:
  - flip_valid arriving in COMMIT, CHECK or PASS is dropped; it is not queued.
  - Latency from flip_valid to D is 1 cycle. From flip_valid to game_over it is 3 cycles.
- Registering: D is registered (Moore). There is no combinational path from any input to any output.
- num_players changes: sampled continuously. If a change makes T exceed num_players, the next PASS wraps T to 0.
- Reset asserted mid-game returns to IDLE immediately. No D pulse is emitted after rst rises.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_FLIP and clears on every entry to WAIT_FLIP.
  - When it reaches TIMEOUT_CYCLES-1 with no flip_valid -> PASS (turn forfeited; turn_cnt increments).
  - If flip_valid coincides with the timeout cycle, the flip wins.
- Undefined: no counter logic exists; WAIT_FLIP waits indefinitely.

Test Plan:
- Reset: rst pulse mid-COMMIT -> all outputs 0 within the same cycle; state IDLE; no further D.
- Match streak: num_players=3, start, then three flip_valid&match with win_in=0 -> three single-cycle D pulses; T stays 0; turn_cnt=0.
- Wrap: num_players=2, four mismatched flips -> T sequence 1,2,0,1; turn_cnt=4; D never asserted.
- Win: T=2, matched flip, win_in=1 on the CHECK cycle -> game_over=1 three cycles after flip_valid; winner=2; busy=0; further flips ignored; start restarts with T=0.
- Dropped flip: flip_valid asserted in the cycle after D (CHECK) -> ignored; exactly one D pulse total.
- Timeout (TURN_TIMEOUT_EN, TIMEOUT_CYCLES=8): no flip for 8 cycles in WAIT_FLIP -> T advances by 1. A flip on cycle 8 -> processed; no forfeit.
